ram_io_responder: RTL

RAM_IO_RESPONDER -- requirements
Module: ram_io_responder

---
 rtl/ram_io_responder_pkg.sv | 18 +
 rtl/ram_io_responder_byte_fifo.sv | 53 +++++
 rtl/ram_io_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ram_io_responder_pkg.sv
// Shared constants for ram_io_responder: access encodings, IO decode values and helpers.
package ram_io_responder_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_e;

  localparam logic [31:0] IO_BASE     = 32'h0003_0000;
  localparam logic [1:0]  IO_SEL      = 2'b11;
  localparam logic [15:0] IO_OFF_DATA = 16'h0000;
  localparam logic [15:0] IO_OFF_STAT = 16'h0004;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ram_io_responder_byte_fifo.sv
// byte_fifo: power-of-2 depth byte FIFO; pointers carry one extra wrap bit to tell full from empty.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       push_drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem [DEPTH];
  logic        do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem[rd_ptr_q[AW-1:0]];

  // A pop frees the slot in the same cycle, so a full FIFO may still accept.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign push_drop = push && !do_push;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ram_io_responder.sv
// Byte RAM plus memory-mapped TX/RX FIFO IO at 0x30000 for a simple memory controller.
// Optional IO_PROG_END_EN adds a sticky prog_end output set by writes to 0x30004.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int unsigned RAM_AW     = 17,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_drop_cnt
`ifdef IO_PROG_END_EN
  ,
  output logic        prog_end
`endif
);

  logic [7:0]        ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;

  mem_op_e     op;
  logic        io_sel;
  logic [15:0] io_off;
  logic        unused_addr_bits;

  logic [7:0] mem_din_q, mem_din_d;
  logic [7:0] tx_drop_cnt_q, tx_drop_cnt_d;

  logic       tx_push, tx_empty, tx_full, tx_push_drop;
  logic       rx_pop, rx_empty, rx_full, rx_drop_unused;
  logic [7:0] rx_head;

`ifdef IO_PROG_END_EN
  logic prog_end_q, prog_end_d;
  assign prog_end = prog_end_q;
`endif

  assign op               = mem_op_e'(mem_wr);
  assign io_sel           = (mem_a[17:16] == IO_SEL);
  assign io_off           = mem_a[15:0] - IO_BASE[15:0];
  assign ram_addr         = mem_a[RAM_AW-1:0];
  assign unused_addr_bits = ^mem_a[31:18];

  assign mem_din     = mem_din_q;
  assign tx_drop_cnt = tx_drop_cnt_q;
  assign tx_valid    = !tx_empty;
  assign rx_ready    = !rx_full;

  always_comb begin
    mem_din_d     = mem_din_q;
    ram_we        = 1'b0;
    tx_push       = 1'b0;
    rx_pop        = 1'b0;
`ifdef IO_PROG_END_EN
    prog_end_d    = prog_end_q;
`endif
    if (op == MEM_WRITE) begin
      if (!io_sel) begin
        ram_we = 1'b1;
      end else if (io_off == IO_OFF_DATA) begin
        tx_push = 1'b1;
      end
`ifdef IO_PROG_END_EN
      else if (io_off == IO_OFF_STAT) begin
        prog_end_d = 1'b1;
      end
`endif
    end else begin
      if (!io_sel) begin
        mem_din_d = ram[ram_addr];
      end else if (io_off == IO_OFF_DATA) begin
        mem_din_d = rx_empty ? '0 : rx_head;
        rx_pop    = 1'b1;
      end else if (io_off == IO_OFF_STAT) begin
        mem_din_d = {6'b0, !rx_empty, tx_full};
      end else begin
        mem_din_d = '0;
      end
    end
    tx_drop_cnt_d = tx_push_drop ? sat_inc8(tx_drop_cnt_q) : tx_drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_din_q     <= '0;
      tx_drop_cnt_q <= '0;
`ifdef IO_PROG_END_EN
      prog_end_q    <= 1'b0;
`endif
    end else begin
      mem_din_q     <= mem_din_d;
      tx_drop_cnt_q <= tx_drop_cnt_d;
`ifdef IO_PROG_END_EN
      prog_end_q    <= prog_end_d;
`endif
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= mem_dout;
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (tx_push),
    .push_data (mem_dout),
    .pop       (tx_ready),
    .head      (tx_data),
    .empty     (tx_empty),
    .full      (tx_full),
    .push_drop (tx_push_drop)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (rx_valid && rx_ready),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full),
    .push_drop (rx_drop_unused)
  );

endmodule
